// File: rtl/polyphase_interp_ctrl.sv
// Delay-line sequencer for a polyphase FIR interpolator: clears the sample RAM,
// writes each accepted sample through port A, then sweeps port B over K taps x L phases.
//
// state   | meaning
// CLEAR   | zero the delay line, one word per cycle
// IDLE    | in_ready high, waiting for a sample
// WRITE   | newest sample on port A; first tap read is issued next
// RUN     | one tap read per cycle, phase outer / tap inner
// FLUSH   | last product drains into the MAC
module polyphase_interp_ctrl #(
    parameter int DW = 16,
    parameter int K  = 8,
    parameter int L  = 4,
    localparam int AW = $clog2(K),
    localparam int PW = (L > 2) ? $clog2(L) : 1,
    localparam int CW = $clog2(L * K)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          ram_en_a,
    output logic          ram_we_a,
    output logic [AW-1:0] ram_addr_a,
    output logic [DW-1:0] ram_din_a,
    output logic          ram_en_b,
    output logic          ram_we_b,
    output logic [AW-1:0] ram_addr_b,
    output logic [CW-1:0] coef_addr,
    output logic          mac_en,
    output logic          mac_clr,
    output logic          out_valid,
    output logic [PW-1:0] phase
);

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_WRITE,
        S_RUN,
        S_FLUSH
    } state_t;

    state_t        state;
    logic [AW-1:0] clr_cnt;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] last;
    logic [AW-1:0] rd_k;
    logic [PW-1:0] rd_p;
    logic          mac_last;
    logic [PW-1:0] mac_p;

    logic [AW-1:0] nxt_k;
    logic [PW-1:0] nxt_p;
    logic          last_read;

    always_comb begin
        nxt_k     = rd_k + AW'(1);
        nxt_p     = (rd_k == AW'(K - 1)) ? rd_p + PW'(1) : rd_p;
        last_read = (rd_k == AW'(K - 1)) && (rd_p == PW'(L - 1));
    end

    assign ram_we_b = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_CLEAR;
            clr_cnt    <= '0;
            wr_ptr     <= '0;
            last       <= '0;
            rd_k       <= '0;
            rd_p       <= '0;
            mac_last   <= 1'b0;
            mac_p      <= '0;
            in_ready   <= 1'b0;
            ram_en_a   <= 1'b0;
            ram_we_a   <= 1'b0;
            ram_addr_a <= '0;
            ram_din_a  <= '0;
            ram_en_b   <= 1'b0;
            ram_addr_b <= '0;
            coef_addr  <= '0;
            mac_en     <= 1'b0;
            mac_clr    <= 1'b0;
            out_valid  <= 1'b0;
            phase      <= '0;
        end else begin
            ram_en_a   <= 1'b0;
            ram_we_a   <= 1'b0;
            ram_addr_a <= '0;
            ram_din_a  <= '0;
            ram_en_b   <= 1'b0;
            ram_addr_b <= '0;
            coef_addr  <= '0;

            // MAC stage trails the port-B read by the RAM's one-cycle latency
            mac_en    <= ram_en_b;
            mac_clr   <= ram_en_b && (rd_k == '0);
            mac_last  <= ram_en_b && (rd_k == AW'(K - 1));
            mac_p     <= rd_p;
            out_valid <= mac_last;
            phase     <= mac_last ? mac_p : '0;

            case (state)
                S_CLEAR: begin
                    ram_en_a   <= 1'b1;
                    ram_we_a   <= 1'b1;
                    ram_addr_a <= clr_cnt;
                    clr_cnt    <= clr_cnt + AW'(1);
                    if (clr_cnt == AW'(K - 1)) begin
                        wr_ptr <= '0;
                        state  <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready   <= 1'b0;
                        ram_en_a   <= 1'b1;
                        ram_we_a   <= 1'b1;
                        ram_addr_a <= wr_ptr;
                        ram_din_a  <= in_data;
                        last       <= wr_ptr;
                        wr_ptr     <= wr_ptr + AW'(1);
                        state      <= S_WRITE;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                S_WRITE: begin
                    ram_en_b   <= 1'b1;
                    ram_addr_b <= last;
                    coef_addr  <= '0;
                    rd_k       <= '0;
                    rd_p       <= '0;
                    state      <= S_RUN;
                end
                S_RUN: begin
                    if (last_read) begin
                        state <= S_FLUSH;
                    end else begin
                        ram_en_b   <= 1'b1;
                        ram_addr_b <= last - nxt_k;
                        coef_addr  <= {nxt_p, nxt_k};
                        rd_k       <= nxt_k;
                        rd_p       <= nxt_p;
                    end
                end
                S_FLUSH: begin
                    in_ready <= 1'b1;
                    state    <= S_IDLE;
                end
                default: state <= S_CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_polyphase_interp_ctrl.sv
// Directed bench for polyphase_interp_ctrl (K=8, L=4) with a small RAM/ROM/MAC model
// for the end-to-end impulse response.
module tb_polyphase_interp_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = 16'h0;
    logic        in_ready;
    logic        ram_en_a, ram_we_a, ram_en_b, ram_we_b;
    logic [2:0]  ram_addr_a, ram_addr_b;
    logic [15:0] ram_din_a;
    logic [4:0]  coef_addr;
    logic        mac_en, mac_clr, out_valid;
    logic [1:0]  phase;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [2:0]  wp;

    logic [15:0] mem [0:7];
    logic [15:0] dout_b;
    logic [7:0]  coef_q;
    logic [31:0] acc;

    polyphase_interp_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .ram_en_a   (ram_en_a),
        .ram_we_a   (ram_we_a),
        .ram_addr_a (ram_addr_a),
        .ram_din_a  (ram_din_a),
        .ram_en_b   (ram_en_b),
        .ram_we_b   (ram_we_b),
        .ram_addr_b (ram_addr_b),
        .coef_addr  (coef_addr),
        .mac_en     (mac_en),
        .mac_clr    (mac_clr),
        .out_valid  (out_valid),
        .phase      (phase)
    );

    always #5 clk = ~clk;

    // Dual-port RAM, coefficient ROM c[i] = i+1, and accumulator
    always @(posedge clk) begin
        if (ram_en_a && ram_we_a) mem[ram_addr_a] <= ram_din_a;
        if (ram_en_b) begin
            dout_b <= mem[ram_addr_b];
            coef_q <= 8'(coef_addr) + 8'd1;
        end
        if (mac_en) acc <= mac_clr ? 32'(dout_b) * 32'(coef_q)
                                   : acc + 32'(dout_b) * 32'(coef_q);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] pk(logic rdy, logic ea, logic wa, logic [2:0] aa,
                                       logic [15:0] da, logic eb, logic wb, logic [2:0] ab,
                                       logic [4:0] ca, logic me, logic mc, logic ov,
                                       logic [1:0] ph);
        return {27'd0, rdy, ea, wa, aa, da, eb, wb, ab, ca, me, mc, ov, ph};
    endfunction

    // strict=0 ignores address/data/phase fields while their qualifier is low
    function automatic logic [63:0] obs(bit strict);
        return pk(in_ready, ram_en_a, ram_we_a,
                  (strict || ram_en_a) ? ram_addr_a : 3'd0,
                  (strict || ram_en_a) ? ram_din_a : 16'd0,
                  ram_en_b, ram_we_b,
                  (strict || ram_en_b) ? ram_addr_b : 3'd0,
                  (strict || ram_en_b) ? coef_addr : 5'd0,
                  mac_en, mac_clr, out_valid,
                  (strict || out_valid) ? phase : 2'd0);
    endfunction

    function automatic logic [63:0] exp_clr(int c);
        return pk(c == 9, c <= 8, c <= 8, (c <= 8) ? 3'(c - 1) : 3'd0, 16'd0,
                  1'b0, 1'b0, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0);
    endfunction

    // Cycle r after the handshake edge, sample s written at address w
    function automatic logic [63:0] exp_run(int r, logic [15:0] s, logic [2:0] w);
        int   j;
        logic eb, me, ov;
        j  = r - 2;
        eb = (r >= 2) && (r <= 33);
        me = (r >= 3) && (r <= 34);
        ov = (r >= 11) && ((r - 3) % 8 == 0);
        return pk(r == 35, r == 1, r == 1, (r == 1) ? w : 3'd0, (r == 1) ? s : 16'd0,
                  eb, 1'b0, eb ? 3'(int'(w) - (j % 8)) : 3'd0, eb ? 5'(j) : 5'd0,
                  me, me && ((r - 3) % 8 == 0), ov, ov ? 2'((r - 11) / 8) : 2'd0);
    endfunction

    task automatic do_reset(input int id);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk($sformatf("rst%0d_now", id), obs(1), 64'd0);
        tick();
        tick();
        chk($sformatf("rst%0d_held", id), obs(1), 64'd0);
        rst_n = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            tick();
            chk($sformatf("rst%0d_clr%0d", id, c), obs(1), exp_clr(c));
        end
        wp = 3'd0;
    endtask

    task automatic sweep(input int id, input logic [15:0] s, input bit keep,
                         input bit pulses, input int abort_r, input int e2e_n);
        int n;
        n = 0;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        chk($sformatf("s%0d_ready", id), {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        in_data  = s;
        tick();
        for (int r = 1; r <= 35; r++) begin
            if (r == abort_r) return;
            if (!keep) begin
                in_valid = pulses && (r == 5 || r == 20);
                if (pulses) in_data = 16'hDEAD;
            end
            chk($sformatf("s%0d_c%0d", id, r), obs(0), exp_run(r, s, wp));
            if (e2e_n >= 0 && r >= 11 && (r - 3) % 8 == 0)
                chk($sformatf("s%0d_acc_p%0d", id, (r - 11) / 8), {32'd0, acc},
                    64'(((r - 11) / 8) * 8 + e2e_n + 1));
            if (r < 35) tick();
        end
        wp = wp + 3'd1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        wp = 3'd0;
        tick();
        do_reset(0);

        sweep(1, 16'h1234, 1'b0, 1'b0, 0, -1);
        sweep(2, 16'hBEEF, 1'b0, 1'b1, 0, -1);

        // reset in cycle 15 of a sweep
        sweep(3, 16'h5A5A, 1'b0, 1'b0, 15, -1);
        do_reset(1);

        for (int i = 0; i < 10; i++)
            sweep(10 + i, 16'h1000 + 16'(i), 1'b1, 1'b0, 0, -1);
        in_valid = 1'b0;

        do_reset(2);
        for (int i = 0; i < 8; i++)
            sweep(30 + i, (i == 0) ? 16'd1 : 16'd0, 1'b1, 1'b0, 0, i);
        in_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/polyphase_interp_ctrl.md
# polyphase_interp_ctrl

Sequencer for the polyphase FIR interpolator's sample delay line, which is held in a true dual-port RAM. After reset it clears the RAM. It then accepts one input sample at a time and writes it through port A as the newest delay-line entry. Next it sweeps port B over all K taps for each of the L phases, driving coefficient-ROM addresses and MAC control in step with the one-cycle RAM read latency. Its outputs connect directly to the RAM ports, the coefficient ROM and the MAC/accumulator.

## Interface
- DW, 16, sample width (RAM word width)
- K, 8, taps per phase = delay-line depth; power of 2, ≥2
- L, 4, interpolation factor = number of phases; power of 2, ≥2
- clk  in  1  single clock, all logic on posedge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input sample offered
- in_data  in  DW  input sample
- in_ready  out  1  controller can accept a sample
- ram_en_a, ram_we_a  out  1 each  port A enable / write enable
- ram_addr_a  out  log2(K)  port A address
- ram_din_a  out  DW  port A write data
- ram_en_b  out  1  port B read enable
- ram_we_b  out  1  constant 0; port B never writes. Integration ties RAM din_b to 0.
- ram_addr_b  out  log2(K)  port B read address
- coef_addr  out  log2(L*K)  coefficient ROM address, aligned with ram_addr_b
- mac_en  out  1  RAM dout_b valid this cycle; MAC accumulates at the edge
- mac_clr  out  1  with mac_en: load the product instead of adding it
- out_valid  out  1  one-cycle strobe: accumulator holds the finished phase result
- phase  out  max(1,log2(L))  phase index of the result flagged by out_valid

## Operation
- All outputs are registered. While rst_n is low, every output is 0, the state is CLEAR and wr_ptr = 0.
- CLEAR:
  - K write cycles: ram_en_a = ram_we_a = 1, ram_din_a = 0, ram_addr_a = 0..K-1.
  - Then go to IDLE; wr_ptr = 0.
- IDLE:
  - in_ready = 1.
  - A handshake (in_valid & in_ready at an edge) latches in_data, drops in_ready and goes to WRITE.
- WRITE (1 cycle):
  - ram_en_a = ram_we_a = 1, ram_addr_a = wr_ptr, ram_din_a = latched sample.
  - last = wr_ptr; wr_ptr increments modulo K, wrapping K-1→0.
- RUN (L*K cycles), phase counter p = 0..L-1 outer, tap counter k = 0..K-1 inner:
  - ram_en_b = 1.
  - ram_addr_b = (last − k) mod K, so k = 0 is the newest sample.
  - coef_addr = p*K + k.
- After p = L-1, k = K-1, go to FLUSH for 1 cycle, then return to IDLE.
- Pipeline stage (one cycle after each RUN read):
  - mac_en = 1.
  - mac_clr = 1 when the read had k = 0.
- out_valid pulses one cycle after the last mac_en of each phase, with phase = p. For p < L-1 that cycle coincides with the next phase's first mac_en/mac_clr. The MAC load happens at the edge, so the accumulator still shows phase p during the strobe.
- in_valid while in_ready = 0 is ignored; in_data is not sampled.
- Port A and port B never address the same location in the same cycle. Each write commits one edge before the first read of it.
- rst_n asserted mid-operation: immediate return to the reset values, then a full CLEAR. Any partial phase is discarded without an out_valid.

## Timing
- Cycle 0 = handshake edge. Cycle 1 = WRITE. Reads occur in cycles 2..L*K+1; FLUSH is cycle L*K+2.
- mac_en is high in cycles 3..L*K+2; mac_clr in cycles p*K+3.
- out_valid in cycles (p+1)*K+3 for p = 0..L-1.
- in_ready re-rises in cycle L*K+3, the same cycle as the final out_valid.
- Sample period: L*K+3 cycles (35 for L=4, K=8). Output rate: L results per input.
- After rst_n deasserts, clear writes occupy cycles 1..K (registered). in_ready = 1 from cycle K+1.

## Test plan
- Reset/clear, defaults: release rst_n → ram_we_a high for exactly 8 cycles, addr 0..7, din 0. in_ready rises 1 cycle later. All other outputs 0.
- Single sample 0x1234: written at addr 0 in cycle 1.
  - Reads in cycles 2..33: addr_b sequence 0,7,6,…,1 repeated 4×; coef_addr 0..31.
  - mac_clr at cycles 3, 11, 19, 27.
  - out_valid at cycles 11, 19, 27, 35 with phase 0..3.
  - in_ready back in cycle 35.
- Back-to-back streaming, in_valid held high, 10 samples: accepts exactly every 35 cycles. Write addresses 0..7, 0, 1 (wrap). 10th sample's first read addr = 1, then 0, 7, ….
- End-to-end impulse with the real RAM, MAC and coefficient ROM loaded with c[i] = i+1: impulse 1 then zeros → output sequence reproduces c[0..31] in polyphase order.
- in_valid during RUN: pulses in cycles 5 and 20 → no write, no state change; out_valid/phase identical to the unpulsed run.
- Reset mid-operation: assert rst_n in cycle 15 of a sweep → outputs 0 immediately. No further out_valid. CLEAR repeats, then the next sample writes addr 0.
